sync_fifo_flags: RTL and testbench
==================================

// Module: sync_fifo_flags
// PURPOSE
//  Single-clock, parametrised FIFO; same-domain successor of the dual-clock FIFO.
//  Adds fill level, programmable almost-full/almost-empty, sticky overflow/underflow, selectable FWFT read mode.
//  Used for buffering between blocks sharing one clock (e.g. register-file <-> ALU/UART datapaths).
// PARAMETERS
//  DATA_WIDTH  8  word width in bits
//  ADDR_WIDTH  3  address bits; DEPTH = 2**ADDR_WIDTH words
//  AE_LEVEL    1  ALMOST_EMPTY asserted when FILL_LEVEL <= AE_LEVEL
//  AF_LEVEL    6  ALMOST_FULL asserted when FILL_LEVEL >= AF_LEVEL; require AE_LEVEL < AF_LEVEL <= DEPTH
//  FWFT        0  0: standard registered read; 1: first-word-fall-through
// PORTS
//  CLK           in   1               clock, rising edge
//  RST           in   1               synchronous reset, active-high
//  W_INC         in   1               write request
//  WR_DATA       in   DATA_WIDTH      write data
//  R_INC         in   1               read request (FWFT: pop/acknowledge head word)
//  RD_DATA       out  DATA_WIDTH      read data
//  RD_VALID      out  1               RD_DATA valid
//  FULL          out  1               FILL_LEVEL == DEPTH
//  EMPTY         out  1               FILL_LEVEL == 0
//  ALMOST_FULL   out  1               FILL_LEVEL >= AF_LEVEL
//  ALMOST_EMPTY  out  1               FILL_LEVEL <= AE_LEVEL
//  FILL_LEVEL    out  ADDR_WIDTH+1    words stored, 0..DEPTH
//  OVERFLOW      out  1               sticky: write attempted while FULL
//  UNDERFLOW     out  1               sticky: read attempted while EMPTY
//  CLR_ERR       in   1               clears OVERFLOW/UNDERFLOW
// BEHAVIOUR
//  - Reset (sync, RST=1 at edge): wr_ptr=rd_ptr=0, FILL_LEVEL=0, EMPTY=1, FULL=0, ALMOST_EMPTY=1,
//    ALMOST_FULL=0, RD_DATA=0, RD_VALID=0, OVERFLOW=0, UNDERFLOW=0. Memory array not reset.
//    Reset mid-operation discards contents; pending RD_VALID deasserts at that edge. RST overrides all inputs.
//  - Write accepted iff W_INC & ~FULL (FULL of current cycle): mem[wr_ptr]<=WR_DATA, wr_ptr+1.
//  - Read accepted iff R_INC & ~EMPTY: rd_ptr+1.
//  - Pointers ADDR_WIDTH bits, wrap DEPTH-1 -> 0 modulo 2**ADDR_WIDTH.
//  - FILL_LEVEL registered: +1 write only, -1 read only, unchanged on both or neither.
//  - All flags decoded from registered FILL_LEVEL; update in the cycle after the accepting edge.
//  - Simultaneous W_INC+R_INC: when EMPTY, write accepted, read rejected (UNDERFLOW set);
//    when FULL, read accepted, write rejected (OVERFLOW set); otherwise both accepted, level unchanged.
//  - OVERFLOW/UNDERFLOW set on rejected request, hold until CLR_ERR; set beats clear in the same cycle.
//  - FWFT=0: accepted read -> RD_DATA=mem[rd_ptr] registered, RD_VALID=1 for exactly one cycle
//    (latency 1); RD_DATA holds last value otherwise.
//  - FWFT=1: RD_VALID=~EMPTY; RD_DATA=mem[rd_ptr] (head word, 0 latency); R_INC pops head.
//    A word written into an empty FIFO appears on RD_DATA the cycle after its write edge.
// TESTING
//  1. Reset, DEPTH=8: write 0x01..0x08 -> FULL=1, ALMOST_FULL=1 from level 6, FILL_LEVEL=8.
//  2. Then W_INC with 0xFF while FULL -> OVERFLOW=1, FILL_LEVEL stays 8; reads return 0x01..0x08 in order, 0xFF never seen.
//  3. R_INC on empty FIFO -> UNDERFLOW=1, RD_VALID=0; CLR_ERR=1 one cycle -> OVERFLOW=UNDERFLOW=0.
//  4. Level 4, W_INC+R_INC together for 20 cycles -> FILL_LEVEL stays 4, pointers wrap, data order preserved.
//  5. FWFT=1: write 0xA5 into empty -> next cycle RD_VALID=1, RD_DATA=0xA5; R_INC -> EMPTY=1, RD_VALID=0.
//  6. Level 5 then RST=1 one cycle -> all outputs at reset values; write 0x3C, read -> RD_DATA=0x3C.

Source files
------------

// File: rtl/sync_fifo_flags_if.sv
// sync_fifo_flags_if
//  Handshake and status bundle for the single-clock flagged FIFO.
//  master : producer/consumer side (drives w_inc, wr_data, r_inc, clr_err)
//  slave  : FIFO side (drives read data, valid, fill level and all flags)
interface sync_fifo_flags_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3
);
   logic                  w_inc;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  r_inc;
   logic                  clr_err;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic [ADDR_WIDTH:0]   fill_level;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output w_inc, wr_data, r_inc, clr_err,
      input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
             fill_level, overflow, underflow
   );

   modport slave (
      input  w_inc, wr_data, r_inc, clr_err,
      output rd_data, rd_valid, full, empty, almost_full, almost_empty,
             fill_level, overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags
//  Single-clock FIFO with registered fill level, programmable almost-full /
//  almost-empty thresholds, sticky overflow/underflow and selectable
//  first-word-fall-through read mode.
//  clk  : rising-edge clock
//  rst  : synchronous reset, active high; discards contents
//  fifo : slave side of sync_fifo_flags_if (requests in, data and flags out)
module sync_fifo_flags #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3,
   parameter int AE_LEVEL   = 1,
   parameter int AF_LEVEL   = 6,
   parameter int FWFT       = 0
) (
   input logic               clk,
   input logic               rst,
   sync_fifo_flags_if.slave  fifo
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AE_L    = (ADDR_WIDTH+1)'(AE_LEVEL);
   localparam logic [ADDR_WIDTH:0] AF_L    = (ADDR_WIDTH+1)'(AF_LEVEL);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH:0]   level;
   logic                  full;
   logic                  empty;
   logic                  wr_acc;
   logic                  rd_acc;
   logic                  overflow_q;
   logic                  underflow_q;

   // Acceptance uses this cycle's registered flags, so a full FIFO can still
   // take a read alongside a rejected write (and vice versa when empty).
   assign full   = (level == DEPTH_L);
   assign empty  = (level == '0);
   assign wr_acc = fifo.w_inc & ~full;
   assign rd_acc = fifo.r_inc & ~empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         level       <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
         if (rd_acc) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
         case ({wr_acc, rd_acc})
            2'b10:   level <= level + (ADDR_WIDTH+1)'(1);
            2'b01:   level <= level - (ADDR_WIDTH+1)'(1);
            default: level <= level;
         endcase
         // a new rejected request wins over a simultaneous clear
         if (fifo.w_inc & full)      overflow_q <= 1'b1;
         else if (fifo.clr_err)      overflow_q <= 1'b0;
         if (fifo.r_inc & empty)     underflow_q <= 1'b1;
         else if (fifo.clr_err)      underflow_q <= 1'b0;
      end
   end

   // storage is deliberately not reset
   always_ff @(posedge clk) begin
      if (!rst && wr_acc) mem[wr_ptr] <= fifo.wr_data;
   end

   assign fifo.full         = full;
   assign fifo.empty        = empty;
   assign fifo.almost_full  = (level >= AF_L);
   assign fifo.almost_empty = (level <= AE_L);
   assign fifo.fill_level   = level;
   assign fifo.overflow     = overflow_q;
   assign fifo.underflow    = underflow_q;

   if (FWFT != 0) begin : g_fwft
      // head word is presented directly; zero while empty so reset shows 0
      assign fifo.rd_data  = empty ? '0 : mem[rd_ptr];
      assign fifo.rd_valid = ~empty;
   end else begin : g_std
      logic [DATA_WIDTH-1:0] rd_data_q;
      logic                  rd_valid_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
         end else begin
            rd_valid_q <= rd_acc;
            if (rd_acc) rd_data_q <= mem[rd_ptr];
         end
      end

      assign fifo.rd_data  = rd_data_q;
      assign fifo.rd_valid = rd_valid_q;
   end
endmodule

// File: tb/tb_sync_fifo_flags.sv
module tb_sync_fifo_flags;
   localparam int DW    = 8;
   localparam int AW    = 3;
   localparam int DEPTH = 8;
   localparam int AE    = 1;
   localparam int AF    = 6;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   sync_fifo_flags_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) f1 ();
   sync_fifo_flags_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) f2 ();

   sync_fifo_flags #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AE_LEVEL(AE),
                     .AF_LEVEL(AF), .FWFT(0)) u_dut (
      .clk  (clk),
      .rst  (rst),
      .fifo (f1)
   );

   sync_fifo_flags #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AE_LEVEL(AE),
                     .AF_LEVEL(AF), .FWFT(1)) u_dut_fwft (
      .clk  (clk),
      .rst  (rst),
      .fifo (f2)
   );

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] model_q [$];
   logic [7:0] exp_q [$];
   bit m_ovf = 1'b0;
   bit m_unf = 1'b0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_flags(input string tag);
      int lvl;
      lvl = model_q.size();
      chk({tag, " fill_level"},   32'(f1.fill_level),   32'(lvl));
      chk({tag, " full"},         32'(f1.full),         32'(lvl == DEPTH));
      chk({tag, " empty"},        32'(f1.empty),        32'(lvl == 0));
      chk({tag, " almost_full"},  32'(f1.almost_full),  32'(lvl >= AF));
      chk({tag, " almost_empty"}, 32'(f1.almost_empty), 32'(lvl <= AE));
      chk({tag, " overflow"},     32'(f1.overflow),     32'(m_ovf));
      chk({tag, " underflow"},    32'(f1.underflow),    32'(m_unf));
   endtask

   // one clock of stimulus on the standard-mode FIFO; model updated at the edge
   task automatic step(input bit w, input logic [7:0] d, input bit r,
                       input bit clr);
      bit full_m;
      bit empty_m;
      f1.w_inc   = w;
      f1.wr_data = d;
      f1.r_inc   = r;
      f1.clr_err = clr;
      full_m  = (model_q.size() == DEPTH);
      empty_m = (model_q.size() == 0);
      @(posedge clk);
      if (r && !empty_m) exp_q.push_back(model_q.pop_front());
      if (w && !full_m)  model_q.push_back(d);
      if (clr) begin
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end
      if (w && full_m)  m_ovf = 1'b1;
      if (r && empty_m) m_unf = 1'b1;
      @(negedge clk);
      f1.w_inc   = 1'b0;
      f1.r_inc   = 1'b0;
      f1.clr_err = 1'b0;
      check_flags("step");
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      f1.w_inc   = 1'b0;
      f1.r_inc   = 1'b0;
      f1.clr_err = 1'b0;
      @(posedge clk);
      model_q.delete();
      exp_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      check_flags("reset");
      chk("reset rd_valid", 32'(f1.rd_valid), 32'd0);
      chk("reset rd_data",  32'(f1.rd_data),  32'd0);
   endtask

   // monitor: every presented read word must match the oldest expected word
   initial begin
      forever begin
         @(negedge clk);
         if (f1.rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL rd_valid: got unexpected word %0h expected none",
                        f1.rd_data);
            end else begin
               chk("rd_data", 32'(f1.rd_data), 32'(exp_q.pop_front()));
            end
         end
      end
   end

   initial begin
      f1.w_inc = 1'b0; f1.wr_data = '0; f1.r_inc = 1'b0; f1.clr_err = 1'b0;
      f2.w_inc = 1'b0; f2.wr_data = '0; f2.r_inc = 1'b0; f2.clr_err = 1'b0;
      @(negedge clk);
      do_reset();

      // fill to full, then overflow, then drain in order
      for (int i = 1; i <= DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
      chk("t1 full", 32'(f1.full), 32'd1);
      chk("t1 level", 32'(f1.fill_level), 32'd8);
      step(1'b1, 8'hFF, 1'b0, 1'b0);
      chk("t2 overflow", 32'(f1.overflow), 32'd1);
      for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

      // underflow, then clear both sticky errors
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("t3 underflow", 32'(f1.underflow), 32'd1);
      chk("t3 rd_valid", 32'(f1.rd_valid), 32'd0);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("t3 cleared", 32'({f1.overflow, f1.underflow}), 32'd0);

      // steady level 4 with simultaneous traffic across pointer wrap
      for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) step(1'b1, 8'($urandom), 1'b1, 1'b0);
      chk("t4 level", 32'(f1.fill_level), 32'd4);
      for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

      // first-word-fall-through instance
      chk("fwft idle empty", 32'(f2.empty), 32'd1);
      chk("fwft idle valid", 32'(f2.rd_valid), 32'd0);
      f2.wr_data = 8'hA5; f2.w_inc = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("fwft valid", 32'(f2.rd_valid), 32'd1);
      chk("fwft head", 32'(f2.rd_data), 32'hA5);
      f2.wr_data = 8'h5A;
      @(posedge clk); @(negedge clk);
      f2.w_inc = 1'b0;
      chk("fwft head held", 32'(f2.rd_data), 32'hA5);
      f2.r_inc = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("fwft second head", 32'(f2.rd_data), 32'h5A);
      chk("fwft level", 32'(f2.fill_level), 32'd1);
      @(posedge clk); @(negedge clk);
      f2.r_inc = 1'b0;
      chk("fwft empty", 32'(f2.empty), 32'd1);
      chk("fwft valid low", 32'(f2.rd_valid), 32'd0);

      // reset mid-operation, then a fresh round trip
      for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
      do_reset();
      step(1'b1, 8'h3C, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);

      // randomized traffic with drifting read/write bias
      for (int i = 0; i < 600; i++) begin
         int wp;
         wp = ((i / 60) % 2 == 0) ? 70 : 30;
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else begin
            step(1'($urandom_range(0, 99) < wp), 8'($urandom),
                 1'($urandom_range(0, 99) >= wp),
                 1'($urandom_range(0, 15) == 0));
         end
      end

      step(1'b0, 8'h00, 1'b0, 1'b0);
      chk("read words drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end
endmodule
